rv32i_decode_stage: RTL and testbench



---
 rtl/rv32i_decode_stage_if.sv | 38 +++
 rtl/rv32i_decode_stage.sv | 119 +++++++++++
 tb/tb_rv32i_decode_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_decode_stage_if.sv
// rv32i_decode_stage_if: fetch, register-file, writeback and execute signals around the decode stage
interface rv32i_decode_stage_if;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_read_addr_1;
    logic [4:0]  rf_read_addr_2;
    logic [31:0] rf_read_data_1;
    logic [31:0] rf_read_data_2;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        id_illegal;
    modport slave (
        input  flush, if_valid, if_instr, if_pc, rf_read_data_1, rf_read_data_2,
               wb_write_enable, wb_write_addr, wb_write_data, id_ready,
        output if_ready, rf_read_addr_1, rf_read_addr_2, id_valid, id_pc, id_rs1_data,
               id_rs2_data, id_rd, id_imm, id_opcode, id_funct3, id_funct7b5, id_illegal
    );
    modport master (
        output flush, if_valid, if_instr, if_pc, rf_read_data_1, rf_read_data_2,
               wb_write_enable, wb_write_addr, wb_write_data, id_ready,
        input  if_ready, rf_read_addr_1, rf_read_addr_2, id_valid, id_pc, id_rs1_data,
               id_rs2_data, id_rd, id_imm, id_opcode, id_funct3, id_funct7b5, id_illegal
    );
endinterface

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: RV32I decode between fetch and execute, with writeback bypass around
// the register file's one-cycle registered read.
module rv32i_decode_stage (
    input logic clk,
    input logic reset,
    rv32i_decode_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, VALID} state_t;
    state_t      r_state;
    logic [31:0] r_instr, r_pc, r_byp_1, r_byp_2;
    logic        r_hit_1, r_hit_2;
    logic [31:0] r_id_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]  r_rd;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7b5, r_illegal;
    logic        w_accept, w_hit_in_1, w_hit_in_2, w_wb_1, w_wb_2;
    logic [31:0] w_instr, w_op_1, w_op_2, w_imm;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [6:0]  w_opc;
    logic        w_is_i, w_is_s, w_is_b, w_is_u, w_is_j, w_is_z, w_illegal;

    assign bus.if_ready = !reset && !bus.flush && (r_state == IDLE || (r_state == VALID && bus.id_ready));
    assign w_accept = bus.if_valid && bus.if_ready;
    assign w_instr = w_accept ? bus.if_instr : r_instr;
    assign bus.rf_read_addr_1 = w_instr[19:15];
    assign bus.rf_read_addr_2 = w_instr[24:20];

    // Writes landing on the accept edge are invisible to the registered read, so remember them.
    assign w_hit_in_1 = bus.wb_write_enable && bus.wb_write_addr != 5'd0 && bus.wb_write_addr == bus.if_instr[19:15];
    assign w_hit_in_2 = bus.wb_write_enable && bus.wb_write_addr != 5'd0 && bus.wb_write_addr == bus.if_instr[24:20];
    assign w_rs1 = r_instr[19:15];
    assign w_rs2 = r_instr[24:20];
    assign w_wb_1 = bus.wb_write_enable && bus.wb_write_addr != 5'd0 && bus.wb_write_addr == w_rs1;
    assign w_wb_2 = bus.wb_write_enable && bus.wb_write_addr != 5'd0 && bus.wb_write_addr == w_rs2;
    assign w_op_1 = w_rs1 == 5'd0 ? '0 : w_wb_1 ? bus.wb_write_data : r_hit_1 ? r_byp_1 : bus.rf_read_data_1;
    assign w_op_2 = w_rs2 == 5'd0 ? '0 : w_wb_2 ? bus.wb_write_data : r_hit_2 ? r_byp_2 : bus.rf_read_data_2;

    assign w_opc = r_instr[6:0];
    assign w_is_i = w_opc inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011};
    assign w_is_s = w_opc == 7'b0100011;
    assign w_is_b = w_opc == 7'b1100011;
    assign w_is_u = w_opc inside {7'b0110111, 7'b0010111};
    assign w_is_j = w_opc == 7'b1101111;
    assign w_is_z = w_opc inside {7'b0110011, 7'b0001111};
    assign w_illegal = !(w_is_i || w_is_s || w_is_b || w_is_u || w_is_j || w_is_z);
    assign w_rd = (w_is_s || w_is_b || w_illegal) ? 5'd0 : r_instr[11:7];
    assign w_imm = w_is_i ? {{20{r_instr[31]}}, r_instr[31:20]} :
                   w_is_s ? {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]} :
                   w_is_b ? {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0} :
                   w_is_u ? {r_instr[31:12], 12'b0} :
                   w_is_j ? {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_instr    <= '0;
            r_pc       <= '0;
            r_byp_1    <= '0;
            r_byp_2    <= '0;
            r_hit_1    <= 1'b0;
            r_hit_2    <= 1'b0;
            r_id_pc    <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_instr <= bus.if_instr;
                r_pc    <= bus.if_pc;
                r_hit_1 <= w_hit_in_1;
                r_hit_2 <= w_hit_in_2;
                r_byp_1 <= bus.wb_write_data;
                r_byp_2 <= bus.wb_write_data;
            end else if (bus.flush) begin
                r_instr <= '0;
                r_hit_1 <= 1'b0;
                r_hit_2 <= 1'b0;
            end
            if (bus.flush) begin
                r_state <= IDLE;
            end else if (r_state == IDLE) begin
                r_state <= w_accept ? READ : IDLE;
            end else if (r_state == READ) begin
                r_state    <= VALID;
                r_id_pc    <= r_pc;
                r_rs1_data <= w_op_1;
                r_rs2_data <= w_op_2;
                r_imm      <= w_imm;
                r_rd       <= w_rd;
                r_opcode   <= w_opc;
                r_funct3   <= r_instr[14:12];
                r_funct7b5 <= r_instr[30];
                r_illegal  <= w_illegal;
            end else if (bus.id_ready) begin
                r_state <= w_accept ? READ : IDLE;
            end else begin
                if (w_wb_1) r_rs1_data <= bus.wb_write_data;
                if (w_wb_2) r_rs2_data <= bus.wb_write_data;
            end
        end
    end

    assign bus.id_valid    = r_state == VALID;
    assign bus.id_pc       = r_id_pc;
    assign bus.id_rs1_data = r_rs1_data;
    assign bus.id_rs2_data = r_rs2_data;
    assign bus.id_rd       = r_rd;
    assign bus.id_imm      = r_imm;
    assign bus.id_opcode   = r_opcode;
    assign bus.id_funct3   = r_funct3;
    assign bus.id_funct7b5 = r_funct7b5;
    assign bus.id_illegal  = r_illegal;
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb_rv32i_decode_stage: directed vectors for the decode stage, checked against an
// architectural model (register file contents plus an in-order queue of accepted instructions).
module tb_rv32i_decode_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [31:0] mem [32];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int acc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    rv32i_decode_stage_if bus();
    rv32i_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

    // Bench-side register file: registered read returning pre-write data, x0 hardwired to zero.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.rf_read_data_1 <= bus.rf_read_addr_1 == 5'd0 ? 32'd0 : mem[bus.rf_read_addr_1];
        bus.rf_read_data_2 <= bus.rf_read_addr_2 == 5'd0 ? 32'd0 : mem[bus.rf_read_addr_2];
        if (bus.wb_write_enable && bus.wb_write_addr != 5'd0) mem[bus.wb_write_addr] <= bus.wb_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] i);
        return i[6:0] inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 32'($signed(i[31:20]));
            7'h23: return 32'($signed({i[31:25], i[11:7]}));
            7'h63: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7'h37, 7'h17: return i & 32'hFFFFF000;
            7'h6F: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] exp_rd(input logic [31:0] i);
        return (!legal(i) || i[6:0] == 7'h23 || i[6:0] == 7'h63) ? 5'd0 : i[11:7];
    endfunction

    function automatic logic [31:0] reg_val(input logic [4:0] r);
        return r == 5'd0 ? 32'd0 : mem[r];
    endfunction

    always @(negedge clk) begin
        logic exp_v, exp_r;
        ent_t e;
        if (reset) begin
            q.delete();
        end else begin
            exp_v = q.size() > 0 && cyc >= q[0].acc + 2;
            exp_r = !bus.flush && (q.size() == 0 || (exp_v && bus.id_ready));
            chk("id_valid", 32'(bus.id_valid), 32'(exp_v));
            chk("if_ready", 32'(bus.if_ready), 32'(exp_r));
            if (exp_v && bus.id_valid) begin
                e = q[0];
                chk("id_pc", bus.id_pc, e.pc);
                chk("id_rs1_data", bus.id_rs1_data, reg_val(e.instr[19:15]));
                chk("id_rs2_data", bus.id_rs2_data, reg_val(e.instr[24:20]));
                chk("id_imm", bus.id_imm, exp_imm(e.instr));
                chk("id_rd", 32'(bus.id_rd), 32'(exp_rd(e.instr)));
                chk("id_opcode", 32'(bus.id_opcode), 32'(e.instr[6:0]));
                chk("id_funct3", 32'(bus.id_funct3), 32'(e.instr[14:12]));
                chk("id_funct7b5", 32'(bus.id_funct7b5), 32'(e.instr[30]));
                chk("id_illegal", 32'(bus.id_illegal), 32'(!legal(e.instr)));
                if (bus.id_ready) void'(q.pop_front());
            end
            if (bus.flush) q.delete();
            if (bus.if_valid && bus.if_ready) q.push_back('{instr: bus.if_instr, pc: bus.if_pc, acc: cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        logic ok = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc = pc;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.if_ready;
            step();
        end
        bus.if_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: pc %h never accepted", pc);
        end
    endtask

    task automatic wait_valid();
        logic ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.id_valid;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL valid_timeout: id_valid never rose");
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_write_enable = 1'b1;
        bus.wb_write_addr = a;
        bus.wb_write_data = d;
    endtask

    task automatic wb_off();
        bus.wb_write_enable = 1'b0;
    endtask

    initial begin
        int seen_pc[$];
        int seen_cyc[$];
        int k;
        logic acc;
        logic [31:0] prog [3];
        prog[0] = 32'hFFF28313;
        prog[1] = 32'h00500393;
        prog[2] = 32'hFE208EE3;
        bus.flush = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc = '0;
        bus.id_ready = 1'b1;
        wb_off();
        bus.wb_write_addr = '0;
        bus.wb_write_data = '0;
        for (int i = 1; i < 32; i++) begin
            wb(5'(i), 32'h1000 + 32'(i));
            step();
        end
        wb(5'd5, 32'h11);
        step();
        wb_off();
        @(negedge clk);
        chk("reset_if_ready", 32'(bus.if_ready), 32'd0);
        chk("reset_id_valid", 32'(bus.id_valid), 32'd0);
        chk("reset_id_pc", bus.id_pc, 32'd0);
        chk("reset_id_imm", bus.id_imm, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("release_if_ready", 32'(bus.if_ready), 32'd1);
        step();

        send(32'hFFF28313, 32'h100);
        @(negedge clk);
        chk("lat_read", 32'(bus.id_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.id_valid), 32'd1);
        chk("addi_rs1", bus.id_rs1_data, 32'h11);
        chk("addi_imm", bus.id_imm, 32'hFFFFFFFF);
        chk("addi_rd", 32'(bus.id_rd), 32'd6);
        step();

        wb(5'd5, 32'hAA);
        send(32'hFFF28313, 32'h104);
        wb_off();
        wait_valid();
        chk("byp_accept", bus.id_rs1_data, 32'hAA);
        step();
        wb(5'd5, 32'h11);
        step();
        wb_off();
        send(32'hFFF28313, 32'h108);
        wb(5'd5, 32'hAA);
        step();
        wb_off();
        wait_valid();
        chk("byp_read", bus.id_rs1_data, 32'hAA);
        step();

        bus.id_ready = 1'b0;
        send(32'hFFF28313, 32'h10C);
        wait_valid();
        step();
        wb(5'd5, 32'h55);
        step();
        wb_off();
        @(negedge clk);
        chk("stall_upd", bus.id_rs1_data, 32'h55);
        chk("stall_valid", 32'(bus.id_valid), 32'd1);
        step();
        wb(5'd0, 32'h99);
        step();
        wb_off();
        @(negedge clk);
        chk("stall_x0", bus.id_rs1_data, 32'h55);
        step();
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        send(32'h00500393, 32'h110);
        wait_valid();
        step();
        wb(5'd0, 32'h99);
        step();
        wb_off();
        @(negedge clk);
        chk("rs_x0", bus.id_rs1_data, 32'd0);
        chk("addi_imm5", bus.id_imm, 32'd5);
        step();
        bus.id_ready = 1'b1;
        step();

        send(32'hFE208EE3, 32'h200);
        wait_valid();
        chk("beq_imm", bus.id_imm, 32'hFFFFFFFC);
        chk("beq_rd", 32'(bus.id_rd), 32'd0);
        step();
        send(32'h123451B7, 32'h204);
        wait_valid();
        chk("lui_imm", bus.id_imm, 32'h12345000);
        chk("lui_rd", 32'(bus.id_rd), 32'd3);
        step();
        send(32'h00000FFF, 32'h208);
        wait_valid();
        chk("ill_flag", 32'(bus.id_illegal), 32'd1);
        chk("ill_imm", bus.id_imm, 32'd0);
        chk("ill_rd", 32'(bus.id_rd), 32'd0);
        step();

        send(32'h00500393, 32'h300);
        bus.flush = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h00100093;
        bus.if_pc = 32'h304;
        @(negedge clk);
        chk("flush_if_ready", 32'(bus.if_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        bus.if_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_valid", 32'(bus.id_valid), 32'd0);
        chk("flush_idle", 32'(bus.if_ready), 32'd1);
        @(negedge clk);
        chk("flush_no_valid2", 32'(bus.id_valid), 32'd0);
        step();

        k = 0;
        bus.if_valid = 1'b1;
        bus.if_pc = 32'd0;
        bus.if_instr = prog[0];
        repeat (10) begin
            @(negedge clk);
            if (bus.id_valid) begin
                seen_pc.push_back(int'(bus.id_pc));
                seen_cyc.push_back(cyc);
            end
            acc = bus.if_valid && bus.if_ready;
            step();
            if (acc) begin
                k++;
                if (k < 3) begin
                    bus.if_pc = 32'(4 * k);
                    bus.if_instr = prog[k];
                end else begin
                    bus.if_valid = 1'b0;
                end
            end
        end
        chk("stream_count", 32'(seen_pc.size()), 32'd3);
        if (seen_pc.size() == 3) begin
            chk("stream_pc0", 32'(seen_pc[0]), 32'd0);
            chk("stream_pc1", 32'(seen_pc[1]), 32'd4);
            chk("stream_pc2", 32'(seen_pc[2]), 32'd8);
            chk("stream_gap1", 32'(seen_cyc[1] - seen_cyc[0]), 32'd2);
            chk("stream_gap2", 32'(seen_cyc[2] - seen_cyc[1]), 32'd2);
        end

        send(32'hFFF28313, 32'h400);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_valid", 32'(bus.id_valid), 32'd0);
        chk("midrst_pc", bus.id_pc, 32'd0);
        chk("midrst_imm", bus.id_imm, 32'd0);
        chk("midrst_if_ready", 32'(bus.if_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_after", 32'(bus.id_valid), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
